// File: rtl/hilo_div_unit_if.sv
// Decoder-to-execute HI/LO control bundle: decoder controls and operands in,
// read data and divider status back out.
interface hilo_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             hilowrite;
  logic             hiloread;
  logic             hilodst;
  logic [5:0]       funct;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [WIDTH-1:0] hilo_out;
  logic             stall;
  logic             div_busy;

  modport master (
    output hilowrite, hiloread, hilodst, funct, srca, srcb,
    input  hilo_out, stall, div_busy
  );

  modport slave (
    input  hilowrite, hiloread, hilodst, funct, srca, srcb,
    output hilo_out, stall, div_busy
  );
endinterface

// File: rtl/hilo_div_unit.sv
// HI/LO register owner: single-cycle moves and multiplies, multi-cycle
// restoring divide that stalls the pipeline while it iterates.
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  hilo_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             is_div_s;
  logic             is_signed_s;
  logic [WIDTH:0]   rem_ext_s;
  logic [WIDTH:0]   rem_sub_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] produ_s;
  logic             hiloread_unused;

  // hiloread only qualifies the read downstream; nothing here depends on it.
  assign hiloread_unused = bus.hiloread;

  assign prod_s  = $signed({{WIDTH{bus.srca[WIDTH-1]}}, bus.srca})
                 * $signed({{WIDTH{bus.srcb[WIDTH-1]}}, bus.srcb});
  assign produ_s = {{WIDTH{1'b0}}, bus.srca} * {{WIDTH{1'b0}}, bus.srcb};

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_raw_d   = dvd_raw_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    rem_ext_s   = {(WIDTH+1){1'b0}};
    rem_sub_s   = {(WIDTH+1){1'b0}};
    is_div_s    = (bus.funct == F_DIV) || (bus.funct == F_DIVU);
    is_signed_s = (bus.funct == F_DIV);

    bus.hilo_out = bus.hilodst ? hi_q : lo_q;
    bus.div_busy = (state_q != S_IDLE);
    bus.stall    = (state_q == S_BUSY)
                || ((state_q == S_IDLE) && bus.hilowrite && is_div_s);

    case (state_q)
      S_IDLE: begin
        if (bus.hilowrite) begin
          case (bus.funct)
            F_MTHI:  hi_d = bus.srca;
            F_MTLO:  lo_d = bus.srca;
            F_MULT:  {hi_d, lo_d} = prod_s;
            F_MULTU: {hi_d, lo_d} = produ_s;
            F_DIV, F_DIVU: begin
              // quo holds the dividend magnitude and shifts into rem one bit per step
              state_d   = S_BUSY;
              quo_d     = (is_signed_s && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
              dvs_d     = (is_signed_s && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
              dvd_raw_d = bus.srca;
              neg_quo_d = is_signed_s && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
              neg_rem_d = is_signed_s && bus.srca[WIDTH-1];
              rem_d     = {WIDTH{1'b0}};
              cnt_d     = {CW{1'b0}};
            end
            default: begin
              hi_d = hi_q;
            end
          endcase
        end else begin
          hi_d = hi_q;
        end
      end
      S_BUSY: begin
        rem_ext_s = {rem_q, quo_q[WIDTH-1]};
        rem_sub_s = rem_ext_s - {1'b0, dvs_q};
        if (rem_ext_s >= {1'b0, dvs_q}) begin
          rem_d = rem_sub_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_ext_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        // Returning to IDLE unconditionally keeps the held DIV request from restarting.
        state_d = S_IDLE;
        if (dvs_q == {WIDTH{1'b0}}) begin
          hi_d = dvd_raw_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          lo_d = neg_quo_q ? -quo_q : quo_q;
          hi_d = neg_rem_q ? -rem_q : rem_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      dvs_q     <= {WIDTH{1'b0}};
      dvd_raw_q <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      dvd_raw_q <= dvd_raw_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: stimulus queues expected values, a
// negedge monitor pops and compares them against the live outputs.
module tb_hilo_div_unit;
  localparam int W = 32;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  localparam int SEL_OUT   = 0;
  localparam int SEL_STALL = 1;
  localparam int SEL_BUSY  = 2;
  localparam int SEL_RUN   = 3;

  typedef struct {
    int          sel;
    string       name;
    logic [31:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst;

  chk_t sb_q[$];
  int   chk_req   = 0;
  int   n_pass    = 0;
  int   n_total   = 0;
  int   stall_run = 0;
  int   last_run  = 0;

  always #5 clk = ~clk;

  hilo_div_unit_if #(.WIDTH(W)) hif ();

  hilo_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  // Length of the most recent run of consecutive stall cycles.
  always @(negedge clk) begin
    if (hif.stall === 1'b1) begin
      stall_run <= stall_run + 1;
    end else begin
      if (stall_run != 0) last_run <= stall_run;
      stall_run <= 0;
    end
  end

  // Monitor: consume the expectations queued for this cycle.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    for (int k = 0; k < chk_req; k++) begin
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_underflow: got empty queue, required an expectation");
      end else begin
        c = sb_q.pop_front();
        case (c.sel)
          SEL_OUT:   act = hif.hilo_out;
          SEL_STALL: act = {31'b0, hif.stall};
          SEL_BUSY:  act = {31'b0, hif.div_busy};
          default:   act = 32'(last_run);
        endcase
        if (act === c.exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", c.name, act, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk_req = 0;
  endtask

  task automatic expect_val(input int sel, input string name, input logic [31:0] exp);
    chk_t c;
    c.sel  = sel;
    c.name = name;
    c.exp  = exp;
    sb_q.push_back(c);
    chk_req++;
  endtask

  task automatic drive(input logic hw, input logic rd, input logic dst,
                       input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    hif.hilowrite = hw;
    hif.hiloread  = rd;
    hif.hilodst   = dst;
    hif.funct     = f;
    hif.srca      = a;
    hif.srcb      = b;
  endtask

  task automatic read_hilo(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
    tick();
    drive(1'b0, 1'b1, 1'b1, 6'b000000, 32'h0, 32'h0);
    expect_val(SEL_OUT, {nm, "_hi"}, ehi);
    tick();
    drive(1'b0, 1'b1, 1'b0, 6'b000000, 32'h0, 32'h0);
    expect_val(SEL_OUT, {nm, "_lo"}, elo);
  endtask

  task automatic div_check(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    bit done;
    tick();
    drive(1'b1, 1'b0, 1'b0, f, a, b);
    expect_val(SEL_STALL, {nm, "_req_stall"}, 32'd1);
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hif.stall === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s_timeout: got stall high for 100 cycles, required it to drop", nm);
    end
    expect_val(SEL_BUSY,  {nm, "_done_busy"},  32'd1);
    expect_val(SEL_STALL, {nm, "_done_stall"}, 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 6'b000000, 32'h0, 32'h0);
    expect_val(SEL_OUT,   {nm, "_hi"},         ehi);
    expect_val(SEL_STALL, {nm, "_after_stall"}, 32'd0);
    expect_val(SEL_BUSY,  {nm, "_after_busy"},  32'd0);
    expect_val(SEL_RUN,   {nm, "_stall_len"},   32'd33);
    tick();
    drive(1'b0, 1'b1, 1'b0, 6'b000000, 32'h0, 32'h0);
    expect_val(SEL_OUT, {nm, "_lo"}, elo);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, F_MTHI, 32'h0000_1234, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 6'b000000, 32'h0, 32'h0);
    expect_val(SEL_OUT,   "reset_hi",    32'h0);
    expect_val(SEL_STALL, "reset_stall", 32'd0);
    expect_val(SEL_BUSY,  "reset_busy",  32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 6'b000000, 32'h0, 32'h0);
    expect_val(SEL_OUT, "reset_lo", 32'h0);

    tick(); drive(1'b1, 1'b0, 1'b0, F_MTHI, 32'hDEAD_BEEF, 32'h0);
    tick(); drive(1'b1, 1'b0, 1'b0, F_MTLO, 32'h00C0_FFEE, 32'h0);
    read_hilo("move", 32'hDEAD_BEEF, 32'h00C0_FFEE);

    tick(); drive(1'b1, 1'b0, 1'b0, F_ADD, 32'hAAAA_AAAA, 32'h5555_5555);
    read_hilo("ignored_funct", 32'hDEAD_BEEF, 32'h00C0_FFEE);

    tick(); drive(1'b1, 1'b0, 1'b0, F_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    tick(); drive(1'b1, 1'b0, 1'b0, F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    div_check(F_DIVU, 32'd100,       32'd7,       32'd2,        32'd14,       "divu_100_7");
    div_check(F_DIV,  32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    div_check(F_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,      32'hFFFF_FFFD, "div_7_m2");
    div_check(F_DIVU, 32'd5,         32'd0,       32'd5,        32'hFFFF_FFFF, "divu_by_zero");
    div_check(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,      32'h8000_0000, "div_minneg_m1");

    tick();
    drive(1'b1, 1'b0, 1'b0, F_DIVU, 32'd100, 32'd7);
    repeat (10) tick();
    expect_val(SEL_STALL, "middiv_busy_stall", 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 6'b000000, 32'h0, 32'h0);
    expect_val(SEL_OUT,   "middiv_rst_hi",    32'h0);
    expect_val(SEL_STALL, "middiv_rst_stall", 32'd0);
    expect_val(SEL_BUSY,  "middiv_rst_busy",  32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 6'b000000, 32'h0, 32'h0);
    expect_val(SEL_OUT, "middiv_rst_lo", 32'h0);

    div_check(F_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, "divu_9_3");

    tick();
    drive(1'b0, 1'b0, 1'b0, 6'b000000, 32'h0, 32'h0);
    tick();
    tick();
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL sb_leftover: got %0d pending expectations, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Execute-stage responder to the main decoder's HI/LO control signals (hilowrite, hiloread, hilodst).
- Owns the architectural HI and LO registers.
- Performs MTHI/MTLO/MULT/MULTU in one cycle and DIV/DIVU with a 32-iteration restoring divider.
- Asserts stall to freeze the pipeline while a divide is in flight.

Parameters:
- WIDTH, 32, operand, HI and LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- hilowrite  input  1  decoder: the instruction writes HI/LO.
- hiloread  input  1  decoder: the instruction is MFHI/MFLO.
- hilodst  input  1  decoder: 1 selects HI, 0 selects LO, for reads and moves.
- funct  input  6  instruction funct field; defines2 codes MTHI, MTLO, MULT, MULTU, DIV, DIVU.
- srca  input  WIDTH  rs value: dividend, multiplicand, or move source.
- srcb  input  WIDTH  rt value: divisor or multiplier.
- hilo_out  output  WIDTH  read data for MFHI/MFLO.
- stall  output  1  holds the pipeline while a divide is busy.
- div_busy  output  1  the divider FSM is not IDLE (debug/perf).

Behaviour:
- Reset (rst=1 at a clk edge): hi=0, lo=0, FSM=IDLE, iteration counter=0, stall=0, div_busy=0. Reset has priority over all activity, including mid-divide; a partial divide is discarded and hi/lo are not updated.
- hilo_out is combinational: hilodst ? hi : lo. It shows committed values and is driven regardless of hiloread. hiloread only qualifies the value for the downstream mux; this block has no internal forwarding.
- Single-cycle writes happen in IDLE when hilowrite=1, and take effect at the next edge:
  - MTHI: hi<=srca.
  - MTLO: lo<=srca.
  - MULT: {hi,lo}<=signed srca*srcb, 64-bit.
  - MULTU: {hi,lo}<=unsigned product.
  - Any other funct with hilowrite=1 is ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when hilowrite=1 and funct is DIV/DIVU. Stall is asserted combinationally in that same cycle. The FSM latches magnitudes (DIV: abs of srca/srcb; DIVU: raw), the sign flags, and the op type, and clears the remainder and counter.
  - BUSY: one restoring step per cycle. Shift {rem,quo} left 1. If rem>=divisor, subtract and set the quotient LSB. The counter increments. Move to DONE after the WIDTH-th step. stall=1 throughout.
  - DONE: stall=0 and div_busy=1. hi<=final remainder and lo<=final quotient at the end of this cycle. The unchanged DIV request still visible on the inputs must NOT restart the FSM. The FSM always returns to IDLE next.
- Stall timing: high for exactly WIDTH+1 consecutive cycles (request cycle plus WIDTH BUSY cycles). An MFHI/MFLO issued right after the DIV reads the new values.
- Signed fixup (DIV only): negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
- Divide by zero: lo=all ones, hi=srca (the raw dividend), no sign fixup. It still takes the full latency.
- Most-negative / -1 (DIV): lo=0x80000000, hi=0.
- While BUSY or DONE, hilowrite requests other than the pending divide are ignored. The stalled pipeline cannot legally present them.

Test Plan:
- Reset: drive rst=1 for 2 cycles with hilowrite=1, MTHI, srca=0x1234 -> hi=lo=0, stall=0, hilo_out=0.
- Moves: MTHI srca=0xDEADBEEF, then MTLO srca=0x00C0FFEE, then hilodst=1 -> hilo_out=0xDEADBEEF; hilodst=0 -> 0x00C0FFEE.
- Multiply with srca=0xFFFFFFFF, srcb=2:
  - MULT -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
- Divide:
  - DIVU 100/7 -> stall high exactly 33 cycles, then hi=2, lo=14. The DIV inputs held in the DONE cycle do not restart the FSM.
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- Corners:
  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Reset mid-divide: start DIVU 100/7, assert rst on BUSY cycle 10 -> next cycle stall=0, div_busy=0, hi=lo=0. A following DIVU 9/3 completes normally with lo=3, hi=0.
